// File: rtl/movegen_sequencer.sv
// Purpose : walks the bitboard move-generation engine through MVV/LVA move enumeration, emitting (from, to) pairs.
// Latency : SETTLE cycles per engine FIND query; one move per accepted handshake, at most.
// Backpress: move_valid holds from/to stable until move_ready; the engine command bus idles (NOP) while stalled.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset (aborts a run without engine cleanup)
//   start / busy / done run control; busy spans accepted start through the done pulse
//   illegal_pos         sticky until next start: the side not to move has its king attacked
//   move_valid/ready    move stream; move_from = aggressor square, move_to = victim square
//   move_count          moves emitted this run, saturating at 255
//   cmd_addr/cmd_data   engine command bus, exactly one command or NOP per cycle
//   eng_result          engine answer: [7] illegal, [6] none-found, [5:0] square
module movegen_sequencer #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       illegal_pos,
    output logic       move_valid,
    input  logic       move_ready,
    output logic [5:0] move_from,
    output logic [5:0] move_to,
    output logic [7:0] move_count,
    output logic [7:0] cmd_addr,
    output logic [7:0] cmd_data,
    input  logic [7:0] eng_result
);

    localparam int CW = $clog2(SETTLE + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_V_ENALL,
        S_V_MASK,
        S_V_FIND,
        S_V_WAIT,
        S_A_ENALL,
        S_A_FIND,
        S_A_WAIT,
        S_EMIT,
        S_A_DIS,
        S_V_DONE,
        S_FIN
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [63:0]   done_mask;    // victims fully enumerated this run
    logic [63:0]   replay_mask;  // working copy consumed while re-disabling done victims
    logic [5:0]    replay_sq;
    logic [5:0]    victim;
    logic [5:0]    aggressor;
    logic [CW-1:0] wait_cnt;
    logic          wait_last;
    logic          illegal_q;
    logic [7:0]    count_q;

    // Lowest set bit of the replay copy: scan high to low so the last hit wins.
    always_comb begin
        replay_sq = 6'd0;
        for (int i = 63; i >= 0; i--) begin
            if (replay_mask[i]) begin
                replay_sq = 6'(i);
            end
        end
    end

    // The counter is loaded with SETTLE on the FIND cycle; the wait state samples
    // on the cycle it steps from 1 to 0, so exactly SETTLE cycles follow the FIND.
    assign wait_last = (wait_cnt == CW'(1));

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_V_ENALL;
            S_V_ENALL: state_nxt = S_V_MASK;
            S_V_MASK:  if (replay_mask == 64'd0) state_nxt = S_V_FIND;
            S_V_FIND:  state_nxt = S_V_WAIT;
            S_V_WAIT: begin
                if (wait_last) begin
                    if (eng_result[7] || eng_result[6]) state_nxt = S_FIN;
                    else                                state_nxt = S_A_ENALL;
                end
            end
            S_A_ENALL: state_nxt = S_A_FIND;
            S_A_FIND:  state_nxt = S_A_WAIT;
            S_A_WAIT: begin
                if (wait_last) begin
                    state_nxt = eng_result[6] ? S_V_DONE : S_EMIT;
                end
            end
            S_EMIT:    if (move_ready) state_nxt = S_A_DIS;
            S_A_DIS:   state_nxt = S_A_FIND;
            S_V_DONE:  state_nxt = S_V_ENALL;
            S_FIN:     state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        cmd_addr = 8'h00;
        cmd_data = 8'h00;
        case (state)
            S_V_ENALL, S_A_ENALL: cmd_addr = 8'hC0;
            S_V_MASK: begin
                if (replay_mask != 64'd0) begin
                    cmd_addr = {4'hD, 2'b00, replay_sq[5:4]};
                    cmd_data = {replay_sq[3:0], 3'b000, 1'b0};
                end
            end
            S_V_FIND: cmd_addr = 8'hE0;
            S_A_FIND: begin
                cmd_addr = {4'hF, 2'b00, victim[5:4]};
                cmd_data = {victim[3:0], 4'b0000};
            end
            // Knock the aggressor just emitted out of the next aggressor search.
            S_A_DIS: begin
                cmd_addr = {4'hD, 2'b00, aggressor[5:4]};
                cmd_data = {aggressor[3:0], 3'b000, 1'b0};
            end
            default: begin
                cmd_addr = 8'h00;
                cmd_data = 8'h00;
            end
        endcase
    end

    assign busy        = (state != S_IDLE);
    assign done        = (state == S_FIN);
    assign move_valid  = (state == S_EMIT);
    assign move_from   = aggressor;
    assign move_to     = victim;
    assign move_count  = count_q;
    assign illegal_pos = illegal_q;

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_mask   <= 64'd0;
            replay_mask <= 64'd0;
            victim      <= 6'd0;
            aggressor   <= 6'd0;
            wait_cnt    <= '0;
            illegal_q   <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        done_mask <= 64'd0;
                        count_q   <= 8'd0;
                        illegal_q <= 1'b0;
                    end
                end
                S_V_ENALL: replay_mask <= done_mask;
                S_V_MASK: begin
                    if (replay_mask != 64'd0) begin
                        replay_mask[replay_sq] <= 1'b0;
                    end
                end
                S_V_FIND, S_A_FIND: wait_cnt <= CW'(SETTLE);
                S_V_WAIT: begin
                    wait_cnt <= wait_cnt - CW'(1);
                    if (wait_last) begin
                        if (eng_result[7]) begin
                            illegal_q <= 1'b1;
                        end else if (!eng_result[6]) begin
                            victim <= eng_result[5:0];
                        end
                    end
                end
                S_A_WAIT: begin
                    wait_cnt <= wait_cnt - CW'(1);
                    if (wait_last && !eng_result[6]) begin
                        aggressor <= eng_result[5:0];
                    end
                end
                S_EMIT: begin
                    if (move_ready && count_q != 8'hFF) begin
                        count_q <= count_q + 8'd1;
                    end
                end
                S_V_DONE: done_mask[victim] <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_movegen_sequencer.sv
// Purpose : directed bench for movegen_sequencer with a small behavioural engine model.
// Latency : engine answers SETTLE cycles after a FIND; earlier reads return a bogus square.
// Backpress: move_ready driven per step; one stalled-consumer scenario.
module tb_movegen_sequencer;

    localparam int SETTLE = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic       done;
    logic       illegal_pos;
    logic       move_valid;
    logic       move_ready;
    logic [5:0] move_from;
    logic [5:0] move_to;
    logic [7:0] move_count;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_data;
    logic [7:0] eng_result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    movegen_sequencer #(.SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .illegal_pos(illegal_pos),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .move_from  (move_from),
        .move_to    (move_to),
        .move_count (move_count),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .eng_result (eng_result)
    );

    // ---------------- engine model ----------------
    // Board is a list of attack edges: aggressor square -> target square, with the
    // target's victim priority and the aggressor's value (lower = less valuable).
    logic [5:0]  e_from [8];
    logic [5:0]  e_to   [8];
    int          e_pri  [8];
    int          e_val  [8];
    int          n_e = 0;
    logic        illegal_cfg = 1'b0;

    logic [63:0] en_mask = '1;
    logic        q_vic = 1'b1;
    logic [5:0]  q_sq = 6'd0;
    int          settle = 0;

    always @(posedge clk) begin
        if (cmd_addr == 8'hC0) en_mask <= '1;
        else if (cmd_addr[7:4] == 4'hD) en_mask[{cmd_addr[1:0], cmd_data[7:4]}] <= cmd_data[0];
        if (cmd_addr == 8'hE0) begin
            q_vic  <= 1'b1;
            settle <= SETTLE - 1;
        end else if (cmd_addr[7:4] == 4'hF) begin
            q_vic  <= 1'b0;
            q_sq   <= {cmd_addr[1:0], cmd_data[7:4]};
            settle <= SETTLE - 1;
        end else if (settle != 0) begin
            settle <= settle - 1;
        end
    end

    int         best_k;
    logic [5:0] best_s;
    always_comb begin
        eng_result = 8'h40;
        best_k     = -1;
        best_s     = 6'd0;
        if (settle != 0) begin
            eng_result = 8'h3F;
        end else if (q_vic) begin
            if (illegal_cfg) begin
                eng_result = 8'h80;
            end else begin
                for (int i = 0; i < 8; i++) begin
                    if (i < n_e && en_mask[e_to[i]] &&
                        (best_k < 0 || e_pri[i] > best_k || (e_pri[i] == best_k && e_to[i] < best_s))) begin
                        best_k = e_pri[i];
                        best_s = e_to[i];
                    end
                end
                if (best_k >= 0) eng_result = {2'b00, best_s};
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (i < n_e && e_to[i] == q_sq && en_mask[e_from[i]] &&
                    (best_k < 0 || e_val[i] < best_k || (e_val[i] == best_k && e_from[i] < best_s))) begin
                    best_k = e_val[i];
                    best_s = e_from[i];
                end
            end
            if (best_k >= 0) eng_result = {2'b00, best_s};
        end
    end

    // ---------------- monitor (samples on the falling edge) ----------------
    logic [5:0] mv_from [64];
    logic [5:0] mv_to   [64];
    logic [7:0] cmd_log [64];
    int mv_n = 0, cmd_n = 0, valid_cnt = 0, cyc_ctr = 0, e0_cyc = 0, done_cyc = 0;

    always @(negedge clk) begin
        cyc_ctr++;
        if (move_valid) valid_cnt++;
        if (move_valid && move_ready && mv_n < 64) begin
            mv_from[mv_n] = move_from;
            mv_to[mv_n]   = move_to;
            mv_n++;
        end
        if ((cmd_addr != 8'h00 || cmd_data != 8'h00) && cmd_n < 64) begin
            cmd_log[cmd_n] = cmd_addr;
            cmd_n++;
        end
        if (cmd_addr == 8'hE0) e0_cyc = cyc_ctr;
        if (done) done_cyc = cyc_ctr;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (cyc < budget) begin
            @(negedge clk);
            if (done) break;
            cyc++;
        end
    endtask

    task automatic do_run(input string tag, input int budget);
        int cyc;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(budget, cyc);
        chk({tag, "_done_seen"}, 64'(cyc < budget), 64'd1);
        @(posedge clk); #1;
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    task automatic chk_move(input string tag, input int idx, input int ef, input int et);
        chk({tag, "_from"}, 64'(mv_from[idx]), 64'(ef));
        chk({tag, "_to"}, 64'(mv_to[idx]), 64'(et));
    endtask

    task automatic set_edge(input int k, input int f, input int t, input int p, input int v);
        e_from[k] = 6'(f);
        e_to[k]   = 6'(t);
        e_pri[k]  = p;
        e_val[k]  = v;
    endtask

    task automatic knight_board(input int pri10);
        set_edge(0, 0, 10, pri10, 3);
        set_edge(1, 0, 17, 0, 3);
        n_e = 2;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int base;
        int vbase;
        int cyc;
        rst_n      = 1'b0;
        start      = 1'b0;
        move_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid", 64'(move_valid), 64'd0);
        chk("rst_cmd", 64'({cmd_addr, cmd_data}), 64'd0);
        chk("rst_count", 64'(move_count), 64'd0);
        chk("rst_illegal", 64'(illegal_pos), 64'd0);
        rst_n = 1'b1;

        // Empty board: one victim search finds nothing.
        n_e   = 0;
        vbase = valid_cnt;
        do_run("empty", 200);
        chk("empty_count", 64'(move_count), 64'd0);
        chk("empty_no_valid", 64'(valid_cnt - vbase), 64'd0);
        chk("empty_ncmd", 64'(cmd_n), 64'd2);
        chk("empty_cmd0", 64'(cmd_log[0]), 64'hC0);
        chk("empty_cmd1", 64'(cmd_log[1]), 64'hE0);
        chk("empty_settle", 64'(done_cyc - e0_cyc), 64'(SETTLE + 1));

        // Lone white knight on sq0: quiet targets tie, lowest index first.
        knight_board(0);
        base = mv_n;
        do_run("knight", 500);
        chk("knight_count", 64'(move_count), 64'd2);
        chk("knight_n", 64'(mv_n - base), 64'd2);
        chk_move("knight_m0", base, 0, 10);
        chk_move("knight_m1", base + 1, 0, 17);

        // Black rook on sq10 raises that victim's priority.
        knight_board(5);
        base = mv_n;
        do_run("rook", 500);
        chk("rook_count", 64'(move_count), 64'd2);
        chk_move("rook_m0", base, 0, 10);
        chk_move("rook_m1", base + 1, 0, 17);

        // Black king attacked: illegal position, no moves.
        illegal_cfg = 1'b1;
        base  = mv_n;
        vbase = valid_cnt;
        do_run("illegal", 500);
        chk("illegal_flag", 64'(illegal_pos), 64'd1);
        chk("illegal_nomoves", 64'(valid_cnt - vbase), 64'd0);
        chk("illegal_count", 64'(move_count), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("illegal_sticky", 64'(illegal_pos), 64'd1);

        // Knight board with the consumer stalled for 5 cycles on the first move.
        illegal_cfg = 1'b0;
        knight_board(0);
        move_ready  = 1'b0;
        base = mv_n;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("stall_illegal_cleared", 64'(illegal_pos), 64'd0);
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            if (move_valid) break;
            cyc++;
        end
        chk("stall_valid_seen", 64'(cyc < 100), 64'd1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 64'(move_valid), 64'd1);
            chk("stall_from", 64'(move_from), 64'd0);
            chk("stall_to", 64'(move_to), 64'd10);
            chk("stall_cmd", 64'({cmd_addr, cmd_data}), 64'd0);
            chk("stall_count", 64'(move_count), 64'd0);
            @(posedge clk); #1;
        end
        move_ready = 1'b1;
        @(negedge clk);
        chk("stall_hs_valid", 64'(move_valid), 64'd1);
        chk("stall_hs_count_before", 64'(move_count), 64'd0);
        @(posedge clk); #1;
        chk("stall_hs_count_after", 64'(move_count), 64'd1);
        wait_done(500, cyc);
        chk("stall_done_seen", 64'(cyc < 500), 64'd1);
        chk("stall_count_final", 64'(move_count), 64'd2);
        chk_move("stall_m0", base, 0, 10);
        chk_move("stall_m1", base + 1, 0, 17);

        // Two aggressors on one victim, plus a higher-priority victim on sq16.
        set_edge(0, 0, 10, 0, 3);
        set_edge(1, 1, 10, 0, 1);
        set_edge(2, 1, 16, 2, 1);
        n_e  = 3;
        base = mv_n;
        do_run("lva", 800);
        chk("lva_count", 64'(move_count), 64'd3);
        chk_move("lva_m0", base, 1, 16);
        chk_move("lva_m1", base + 1, 1, 10);
        chk_move("lva_m2", base + 2, 0, 10);

        // Reset while waiting on the first aggressor search, then regenerate.
        knight_board(0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            if (cmd_addr == 8'hF0) break;
            cyc++;
        end
        chk("abort_afind_seen", 64'(cyc < 100), 64'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_valid", 64'(move_valid), 64'd0);
        chk("abort_cmd", 64'({cmd_addr, cmd_data}), 64'd0);
        chk("abort_count", 64'(move_count), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        base = mv_n;
        do_run("rerun", 500);
        chk("rerun_count", 64'(move_count), 64'd2);
        chk_move("rerun_m0", base, 0, 10);
        chk_move("rerun_m1", base + 1, 0, 17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/movegen_sequencer.md
Name: movegen_sequencer

Overview:
- Sequences the bitboard move-generation engine, which takes an 8-bit command bus and returns an 8-bit result, to enumerate all pseudo-legal moves in most-valuable-victim / least-valuable-aggressor order.
- Alternates FIND-VICTIM and FIND-AGGRESSOR searches and manages the engine's shared enable mask via SET-ENABLE / ENABLE-ALL.
- Emits (from, to) pairs over a valid/ready stream.
- Sits between the host command mux and the engine.

Parameters:
- SETTLE, 2, cycles waited after a FIND command before sampling eng_result (≥1); covers the engine's long combinational ripple.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin generation (accepted only in IDLE)
- busy  out  1  high from the accepted start until the cycle done pulses (inclusive)
- done  out  1  one-cycle pulse at end of generation
- illegal_pos  out  1  sticky until next start; side not to move has its king attacked
- move_valid  out  1  move available
- move_ready  in  1  consumer accepts move
- move_from  out  6  aggressor square
- move_to  out  6  victim square
- move_count  out  8  moves emitted this run, saturating at 255
- cmd_addr  out  8  engine command address
- cmd_data  out  8  engine command data
- eng_result  in  8  engine output: [7] illegal, [6] none-found, [5:0] square

Behaviour:
- Command encodings:
  - NOP: addr=00, data=00.
  - ENABLE-ALL: addr=C0.
  - SET-ENABLE(s,v): addr={4'hD,2'b00,s[5:4]}, data={s[3:0],3'b0,v}.
  - FIND-VICTIM: addr=E0.
  - FIND-AGGRESSOR(s): addr={4'hF,2'b00,s[5:4]}, data={s[3:0],4'b0}.
- Exactly one command is driven per cycle; the bus is NOP in every other cycle.
- Reset values:
  - cmd bus NOP; all outputs 0.
  - done_mask (64-bit internal) 0.
  - State IDLE.
- Reset mid-run aborts immediately to the same values; no engine cleanup is issued.
- States:
  - IDLE: on start, clear done_mask, move_count and illegal_pos → V_ENALL.
  - V_ENALL: issue ENABLE-ALL → V_MASK.
  - V_MASK: while done_mask has set bits, issue SET-ENABLE(lowest set bit not yet replayed, 0), one per cycle; when none remain → V_FIND. A replay cursor/copy is used so done_mask is not destroyed.
  - V_FIND: issue FIND-VICTIM, load wait counter with SETTLE → V_WAIT.
  - V_WAIT: count down; at zero sample eng_result.
    - If bit7 set: illegal_pos=1 → FIN.
    - Else if bit6 set → FIN.
    - Else latch victim=[5:0] → A_ENALL.
  - A_ENALL: issue ENABLE-ALL → A_FIND.
  - A_FIND: issue FIND-AGGRESSOR(victim) → A_WAIT.
  - A_WAIT: count SETTLE; at zero sample.
    - If bit6 set → V_DONE.
    - Else latch aggressor → EMIT.
  - EMIT: move_valid=1 with from=aggressor, to=victim. from/to are held stable while valid and not ready. On valid&&ready: move_count++ (saturating) → A_DIS.
  - A_DIS: issue SET-ENABLE(aggressor, 0) → A_FIND.
  - V_DONE: set done_mask[victim] → V_ENALL.
  - FIN: done=1 for one cycle, busy drops in the following cycle → IDLE.
- start while busy is ignored.
- move_ready while not valid is ignored.
- A victim with no aggressor is marked done without emitting anything.
- Search order follows the engine: highest priority first; ties go to the lowest square index.
- Termination bound: each victim at most 64 aggressors; at most 64 victims.

Test Plan:
- Reset engine (all squares empty), start → V_WAIT sees none; done pulse; move_count=0; move_valid never asserted; cmd sequence is C0, E0, NOP×SETTLE.
- White knight on sq0 only (set via host before start) → moves (0,10) then (0,17), in that order; move_count=2; done.
- White knight sq0 + black rook sq10 → first move (0,10) (rook victim, priority 5), then (0,17); move_count=2.
- Same as previous but black king on sq10 → illegal_pos=1; no moves; done pulses; illegal_pos holds until next start.
- Knight-only board with move_ready held low 5 cycles on first move → move_valid, from=0, to=10 stable for all 5 cycles; cmd bus NOP throughout; count increments only on the handshake cycle.
- Assert rst_n low during A_WAIT → next cycle busy=0, move_valid=0, cmd NOP; a subsequent start regenerates the full move list identically.
